reset_sequencer: RTL

//  Parametrised successor to the single-output reset synchroniser at the SoC top level.
//  - Takes board arstn; produces NUM_DOMAINS active-high resets released in order,

---
 rtl/reset_pkg.sv | 23 ++
 rtl/reset_sync_chain.sv | 20 ++
 rtl/reset_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/reset_pkg.sv
// Shared types and helpers for the reset sequencer.
// Holds the reset cause and FSM state enums and the counter-width helper.
package reset_pkg;

   typedef enum logic [1:0] {
      RC_POR  = 2'd0,
      RC_SOFT = 2'd1,
      RC_WDT  = 2'd2
   } rst_cause_t;

   typedef enum logic [1:0] {
      RS_SYNC,
      RS_HOLD,
      RS_RELEASE,
      RS_RUN
   } rst_state_t;

   // Bits needed to hold values 0..n-1 (at least 1).
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Async-assert / sync-deassert reset synchroniser.
// Ports: clk, arstn (async active-low in), rst_n_sync (active-low out).
module reset_sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic arstn,
   output logic rst_n_sync
);

   logic [STAGES-1:0] q;

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) q <= '0;
      else        q <= {q[STAGES-2:0], 1'b1};
   end

   assign rst_n_sync = q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Ordered multi-domain reset release with soft reset, cause and optional
// watchdog (enable with macro RST_WDT_EN).
// Ports: clk, arstn (board reset), soft_rst_req, wdt_kick,
//   rst_out[NUM_DOMAINS] (active high), rst_done, rst_cause[2].
module reset_sequencer
   import reset_pkg::*;
#(
   parameter int NUM_DOMAINS   = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int HOLD_CYCLES   = 16,
   parameter int RELEASE_DELAY = 8,
   parameter int WDT_TIMEOUT   = 2**20
) (
   input  logic                   clk,
   input  logic                   arstn,
   input  logic                   soft_rst_req,
   input  logic                   wdt_kick,
   output logic [NUM_DOMAINS-1:0] rst_out,
   output logic                   rst_done,
   output logic [1:0]             rst_cause
);

   localparam int CMAX = (HOLD_CYCLES > RELEASE_DELAY) ?
                         HOLD_CYCLES : RELEASE_DELAY;
   localparam int CW = cnt_width(CMAX);
   localparam int IW = cnt_width(NUM_DOMAINS);
   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] REL_LD  = CW'(RELEASE_DELAY - 1);
   localparam logic [IW-1:0] LAST    = IW'(NUM_DOMAINS - 1);

   logic sync_rel;

   reset_sync_chain #(
      .STAGES(SYNC_STAGES)
   ) u_sync (
      .clk       (clk),
      .arstn     (arstn),
      .rst_n_sync(sync_rel)
   );

   rst_state_t             state, state_nx;
   logic [CW-1:0]          cnt, cnt_nx;
   logic [IW-1:0]          idx, idx_nx, nxt_idx;
   logic [NUM_DOMAINS-1:0] out_nx;
   logic                   done_nx;
   rst_cause_t             cause, cause_nx;
   logic                   wdt_fire;

`ifdef RST_WDT_EN
   localparam int WW = cnt_width(WDT_TIMEOUT);
   localparam logic [WW-1:0] WDT_LD = WW'(WDT_TIMEOUT - 1);
   logic [WW-1:0] wdt_cnt;

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn)
         wdt_cnt <= '0;
      else if (state != RS_RUN || wdt_kick)
         wdt_cnt <= WDT_LD;
      else if (wdt_cnt != '0)
         wdt_cnt <= wdt_cnt - 1'b1;
   end

   assign wdt_fire = (state == RS_RUN) && (wdt_cnt == '0) && !wdt_kick;
`else
   logic unused_kick;
   assign unused_kick = wdt_kick;
   assign wdt_fire = 1'b0;
`endif

   // SYNC with the release seen counts as a HOLD cycle, so the hold
   // window starts on the first edge that observes the synchronised release.
   logic active, hold_tick, rel_tick, trig;

   assign active    = (state != RS_SYNC) || sync_rel;
   assign hold_tick = (state == RS_HOLD) || (state == RS_SYNC && sync_rel);
   assign rel_tick  = (state == RS_RELEASE);
   assign trig      = active && (soft_rst_req || wdt_fire);
   assign nxt_idx   = idx + 1'b1;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      idx_nx   = idx;
      out_nx   = rst_out;
      done_nx  = rst_done;
      cause_nx = cause;
      priority case (1'b1)
         trig: begin
            state_nx = RS_HOLD;
            cnt_nx   = HOLD_LD;
            out_nx   = '1;
            done_nx  = 1'b0;
            cause_nx = soft_rst_req ? RC_SOFT : RC_WDT;
         end
         hold_tick: begin
            if (cnt == '0) begin
               out_nx[0] = 1'b0;
               idx_nx    = '0;
               cnt_nx    = REL_LD;
               if (NUM_DOMAINS == 1) begin
                  state_nx = RS_RUN;
                  done_nx  = 1'b1;
               end else begin
                  state_nx = RS_RELEASE;
               end
            end else begin
               state_nx = RS_HOLD;
               cnt_nx   = cnt - 1'b1;
            end
         end
         rel_tick: begin
            if (cnt == '0) begin
               out_nx[nxt_idx] = 1'b0;
               idx_nx          = nxt_idx;
               cnt_nx          = REL_LD;
               if (nxt_idx == LAST) begin
                  state_nx = RS_RUN;
                  done_nx  = 1'b1;
               end
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         default: begin
            if (state == RS_SYNC) cnt_nx = HOLD_LD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state    <= RS_SYNC;
         cnt      <= '0;
         idx      <= '0;
         rst_out  <= '1;
         rst_done <= 1'b0;
         cause    <= RC_POR;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         idx      <= idx_nx;
         rst_out  <= out_nx;
         rst_done <= done_nx;
         cause    <= cause_nx;
      end
   end

   assign rst_cause = cause;

endmodule
